// File: rtl/score_display_pkg.sv
// Shared types and constants for the score-to-7-segment display driver.
package score_display_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    // Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Decimal glyph table; anything above 9 renders as blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3f;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5b;
            4'd3:    seg = 7'h4f;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6d;
            4'd6:    seg = 7'h7d;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7f;
            4'd9:    seg = 7'h6f;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // 10**n, used to derive the overflow threshold at elaboration time.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-to-segment encoder; dash overrides blank, blank overrides glyph.
module seg7_encode
    import score_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    // Select dash, blank or the decimal glyph.
    always_comb begin
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = seg_glyph(digit_i);
        end
    end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to packed BCD (serial double-dabble) with registered 7-segment outputs.
module score_bcd_display
    import score_display_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned NUM_DIGITS    = 3,
    parameter int unsigned BLANK_LEADING = 1,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    ready,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned ACC_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 7 * NUM_DIGITS;
    localparam int unsigned THR_W = ((DATA_W > ACC_W) ? DATA_W : ACC_W) + 1;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [THR_W-1:0] OVF_THR = THR_W'(pow10(NUM_DIGITS));

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [HEX_W-1:0]    hex_q, hex_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    logic [ACC_W-1:0]        acc_adj;
    logic [ACC_W+DATA_W-1:0] shifted;
    logic [NUM_DIGITS-1:0]   blank_d;
    logic [HEX_W-1:0]        seg_act;
    logic [HEX_W-1:0]        hex_rst;
    logic                    lead;

    // Conversion FSM next state: add-3 correction then shift {acc,shreg} left by one.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        // Ready drops one edge after the accept and returns on the commit edge.
        ready_d    = (state_q != StShift);

        acc_adj = acc_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {acc_adj, shreg_q} << 1;

        unique case (state_q)
            StIdle: begin
                if (load && ready_q) begin
                    state_d    = StShift;
                    shreg_d    = data_in;
                    acc_d      = '0;
                    cnt_d      = CNT_W'(DATA_W);
                    ovf_pend_d = (THR_W'(data_in) >= OVF_THR);
                end
            end
            StShift: begin
                acc_d   = shifted[ACC_W+DATA_W-1:DATA_W];
                shreg_d = shifted[DATA_W-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                bcd_d   = ovf_pend_q ? {NUM_DIGITS{4'h9}} : acc_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Leading-zero detection from the most significant digit downward.
    always_comb begin
        lead    = 1'b1;
        blank_d = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lead       = lead && (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = (BLANK_LEADING != 0) && (i != 0) && lead;
        end
    end

    genvar g;
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_encode u_enc (
            .digit_i (bcd_d[4*g +: 4]),
            .blank_i (blank_d[g]),
            .dash_i  (ovf_d),
            .seg_o   (seg_act[7*g +: 7])
        );
        // Reset image: "0" on the units digit, zero or blank above it.
        if (g == 0 || BLANK_LEADING == 0) begin : g_zero
            assign hex_rst[7*g +: 7] = (ACTIVE_LOW != 0) ? ~seg_glyph(4'd0) : seg_glyph(4'd0);
        end else begin : g_blank
            assign hex_rst[7*g +: 7] = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
        end
    end

    // Output polarity applied ahead of the hex register.
    always_comb begin
        hex_d = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            hex_q      <= hex_rst;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            hex_q      <= hex_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: three configurations checked every cycle against a decimal model.
module tb_score_bcd_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  load;
    logic [15:0] din [3];
    logic [2:0]  rdy;
    logic [2:0]  dn;
    logic [2:0]  ov;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [15:0] bcd2;
    logic [20:0] hex0;
    logic [13:0] hex1;
    logic [27:0] hex2;
    logic [31:0] bcd_a [3];
    logic [55:0] hex_a [3];

    assign bcd_a[0] = 32'(bcd0);
    assign bcd_a[1] = 32'(bcd1);
    assign bcd_a[2] = 32'(bcd2);
    assign hex_a[0] = 56'(hex0);
    assign hex_a[1] = 56'(hex1);
    assign hex_a[2] = 56'(hex2);

    score_bcd_display #(.DATA_W(8), .NUM_DIGITS(3), .BLANK_LEADING(1), .ACTIVE_LOW(1)) u_dut0 (
        .Clock(clk), .reset(rst[0]), .load(load[0]), .data_in(din[0][7:0]), .ready(rdy[0]),
        .done(dn[0]), .overflow(ov[0]), .bcd_out(bcd0), .hex_out(hex0)
    );
    score_bcd_display #(.DATA_W(8), .NUM_DIGITS(2), .BLANK_LEADING(1), .ACTIVE_LOW(1)) u_dut1 (
        .Clock(clk), .reset(rst[1]), .load(load[1]), .data_in(din[1][7:0]), .ready(rdy[1]),
        .done(dn[1]), .overflow(ov[1]), .bcd_out(bcd1), .hex_out(hex1)
    );
    score_bcd_display #(.DATA_W(10), .NUM_DIGITS(4), .BLANK_LEADING(0), .ACTIVE_LOW(0)) u_dut2 (
        .Clock(clk), .reset(rst[2]), .load(load[2]), .data_in(din[2][9:0]), .ready(rdy[2]),
        .done(dn[2]), .overflow(ov[2]), .bcd_out(bcd2), .hex_out(hex2)
    );

    localparam int unsigned DW [3] = '{8, 8, 10};
    localparam int unsigned ND [3] = '{3, 2, 4};
    localparam int unsigned BL [3] = '{1, 1, 0};
    localparam int unsigned AL [3] = '{1, 1, 0};

    // Active-low glyphs as listed for DE-series boards.
    localparam logic [6:0] GLYPH_L [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK_L = 7'b1111111;
    localparam logic [6:0] DASH_L  = 7'b0111111;

    int n_tests = 0;
    int n_fail  = 0;
    int ndone0  = 0;
    bit chk_en  = 1'b0;

    function automatic int unsigned p10(input int unsigned n);
        int unsigned r = 1;
        for (int k = 0; k < int'(n); k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] f_bcd(input int i, input int unsigned v);
        logic [31:0] r = '0;
        for (int d = 0; d < int'(ND[i]); d++) begin
            if (v >= p10(ND[i])) r[4*d +: 4] = 4'h9;
            else r[4*d +: 4] = 4'((v / p10(d)) % 10);
        end
        return r;
    endfunction

    function automatic logic [55:0] f_hex(input int i, input int unsigned v);
        logic [55:0] r = '0;
        logic [6:0]  s;
        for (int d = 0; d < int'(ND[i]); d++) begin
            if (v >= p10(ND[i])) s = DASH_L;
            else if (BL[i] != 0 && d > 0 && v < p10(d)) s = BLANK_L;
            else s = GLYPH_L[(v / p10(d)) % 10];
            r[7*d +: 7] = (AL[i] != 0) ? s : ~s;
        end
        return r;
    endfunction

    // Model: accept when idle, commit exactly DATA_W+1 edges after the accept edge.
    int unsigned m_rem   [3];
    int unsigned m_pend  [3];
    logic        m_ready [3];
    logic        m_done  [3];
    logic        m_ovf   [3];
    logic [31:0] m_bcd   [3];
    logic [55:0] m_hex   [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_rem[i]   <= 0;
                m_ready[i] <= 1'b1;
                m_done[i]  <= 1'b0;
                m_ovf[i]   <= 1'b0;
                m_bcd[i]   <= '0;
                m_hex[i]   <= f_hex(i, 0);
            end else begin
                m_done[i] <= 1'b0;
                if (m_rem[i] == 0) begin
                    m_ready[i] <= 1'b1;
                    if (load[i]) begin
                        m_rem[i]  <= DW[i] + 1;
                        m_pend[i] <= 32'(din[i]);
                    end
                end else begin
                    m_rem[i]   <= m_rem[i] - 1;
                    m_ready[i] <= (m_rem[i] == 1) || (m_rem[i] - 1 > DW[i]);
                    if (m_rem[i] == 1) begin
                        m_bcd[i]  <= f_bcd(i, m_pend[i]);
                        m_hex[i]  <= f_hex(i, m_pend[i]);
                        m_ovf[i]  <= (m_pend[i] >= p10(ND[i]));
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, want %0h", name, inst, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("ready", i, 64'(rdy[i]), 64'(m_ready[i]));
                chk("done", i, 64'(dn[i]), 64'(m_done[i]));
                chk("overflow", i, 64'(ov[i]), 64'(m_ovf[i]));
                chk("bcd", i, 64'(bcd_a[i]), 64'(m_bcd[i]));
                chk("hex", i, 64'(hex_a[i]), 64'(m_hex[i]));
            end
            if (dn[0]) ndone0++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst  = 3'b111;
        load = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = '0;
        step(3);
        chk_en = 1'b1;
        chk("rst_ready", 0, 64'(rdy[0]), 64'd1);
        chk("rst_bcd", 0, 64'(bcd0), 64'h000);
        chk("rst_hex", 0, 64'(hex0), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
        chk("rst_hex", 2, 64'(hex2), 64'({4{7'b0111111}}));
        rst = 3'b000;

        // 47: latency DATA_W+1, single done pulse.
        load[0] = 1'b1; din[0] = 16'd47;
        step(1);
        load[0] = 1'b0; din[0] = 16'haa;
        step(8);
        chk("hold_bcd", 0, 64'(bcd0), 64'h000);
        chk("busy_ready", 0, 64'(rdy[0]), 64'd0);
        step(1);
        chk("bcd47", 0, 64'(bcd0), 64'h047);
        chk("hex47", 0, 64'(hex0), 64'({7'b1111111, 7'b0011001, 7'b1111000}));
        chk("done47", 0, 64'(dn[0]), 64'd1);
        step(1);
        chk("done47_end", 0, 64'(dn[0]), 64'd0);

        // 255 on three digits and on two digits (overflow), then 5.
        load[1:0] = 2'b11; din[0] = 16'd255; din[1] = 16'd255;
        step(1);
        load[1:0] = 2'b00;
        step(9);
        chk("bcd255", 0, 64'(bcd0), 64'h255);
        chk("ovf255", 0, 64'(ov[0]), 64'd0);
        chk("bcd255", 1, 64'(bcd1), 64'h99);
        chk("ovf255", 1, 64'(ov[1]), 64'd1);
        chk("hex255", 1, 64'(hex1), 64'({7'b0111111, 7'b0111111}));
        step(1);
        load[1] = 1'b1; din[1] = 16'd5;
        step(1);
        load[1] = 1'b0;
        step(9);
        chk("ovf5", 1, 64'(ov[1]), 64'd0);
        chk("hex5", 1, 64'(hex1), 64'({7'b1111111, 7'b0010010}));
        step(1);

        // Threshold boundary on two digits: 99 fits, 100 overflows.
        load[1] = 1'b1; din[1] = 16'd99;
        step(1);
        load[1] = 1'b0;
        step(9);
        chk("bcd99", 1, 64'(bcd1), 64'h99);
        chk("ovf99", 1, 64'(ov[1]), 64'd0);
        step(1);
        load[1] = 1'b1; din[1] = 16'd100;
        step(1);
        load[1] = 1'b0;
        step(9);
        chk("ovf100", 1, 64'(ov[1]), 64'd1);
        step(1);

        // Load during SHIFT is ignored.
        ndone0 = 0;
        load[0] = 1'b1; din[0] = 16'd100;
        step(1);
        load[0] = 1'b0;
        step(3);
        load[0] = 1'b1; din[0] = 16'd33;
        step(1);
        load[0] = 1'b0;
        step(12);
        chk("bcd100", 0, 64'(bcd0), 64'h100);
        chk("ndone100", 0, 64'(ndone0), 64'd1);

        // Reset in the 4th SHIFT cycle aborts the conversion.
        ndone0 = 0;
        load[0] = 1'b1; din[0] = 16'd200;
        step(1);
        load[0] = 1'b0;
        step(3);
        rst[0] = 1'b1;
        step(1);
        rst[0] = 1'b0;
        chk("abort_bcd", 0, 64'(bcd0), 64'h000);
        chk("abort_ready", 0, 64'(rdy[0]), 64'd1);
        chk("abort_hex", 0, 64'(hex0), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
        step(12);
        chk("abort_ndone", 0, 64'(ndone0), 64'd0);
        load[0] = 1'b1; din[0] = 16'd9;
        step(1);
        load[0] = 1'b0;
        step(9);
        chk("bcd9", 0, 64'(bcd0), 64'h009);
        chk("hex9", 0, 64'(hex0), 64'({7'b1111111, 7'b1111111, 7'b0010000}));
        step(1);

        // Reset and load together: load dropped.
        rst[1] = 1'b1; load[1] = 1'b1; din[1] = 16'd77;
        step(1);
        rst[1] = 1'b0; load[1] = 1'b0;
        step(12);
        chk("rstload_bcd", 1, 64'(bcd1), 64'h00);
        chk("rstload_ovf", 1, 64'(ov[1]), 64'd0);

        // Load in the done cycle is accepted.
        load[0] = 1'b1; din[0] = 16'd12;
        step(1);
        load[0] = 1'b0;
        step(9);
        chk("done12", 0, 64'(dn[0]), 64'd1);
        load[0] = 1'b1; din[0] = 16'd34;
        step(1);
        load[0] = 1'b0;
        step(9);
        chk("bcd34", 0, 64'(bcd0), 64'h034);
        step(1);

        // Ten-bit, four-digit, no blanking, active-high.
        load[2] = 1'b1; din[2] = 16'd1000;
        step(1);
        load[2] = 1'b0;
        step(10);
        chk("hold1000", 2, 64'(bcd2), 64'h0000);
        step(1);
        chk("bcd1000", 2, 64'(bcd2), 64'h1000);
        chk("hex1000", 2, 64'(hex2), 64'({7'b0000110, 7'b0111111, 7'b0111111, 7'b0111111}));
        chk("done1000", 2, 64'(dn[2]), 64'd1);
        step(1);
        load[2] = 1'b1; din[2] = 16'd5;
        step(1);
        load[2] = 1'b0;
        step(11);
        chk("hex0005", 2, 64'(hex2), 64'({7'b0111111, 7'b0111111, 7'b0111111, 7'b1101101}));
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
